// File: rtl/sys_clk_seq_if.sv
//------------------------------------------------------------------------------
// Module   : sys_clk_seq_if
// Purpose  : SPI clock-rate change handshake (4-phase req/ack with rate select).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sys_clk_seq_if;
  logic rate_req;   // level request for a rate change
  logic rate_sel;   // 0 = 12.5 MHz, 1 = 50 MHz; valid while rate_req is high
  logic rate_ack;   // level acknowledge

  // Requester side
  modport master (
    output rate_req,
    output rate_sel,
    input  rate_ack
  );

  // Sequencer side
  modport slave (
    input  rate_req,
    input  rate_sel,
    output rate_ack
  );
endinterface

`default_nettype wire

// File: rtl/sys_clk_seq.sv
//------------------------------------------------------------------------------
// Module   : sys_clk_seq
// Purpose  : Reference-clocked sequencer for MMCM lock: holds system reset until
//            lock is stable, performs glitch-safe SPI x2 clock-mux switching and
//            tracks loss-of-lock events.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sys_clk_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int QUIESCE_CYCLES     = 16,
  parameter int SETTLE_CYCLES      = 64,
  parameter int LOSS_CNT_W         = 8
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   mmcm_locked,
  sys_clk_seq_if.slave          rate_if,
  output logic                  spi_clk_x2_sel,
  output logic                  spi_quiesce,
  output logic                  sys_rst_n_out,
  output logic                  lock_lost,
  input  wire                   lock_lost_clr,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            seq_state
);

  localparam int c_stable_w = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int c_phase_max = (QUIESCE_CYCLES > SETTLE_CYCLES) ? QUIESCE_CYCLES : SETTLE_CYCLES;
  localparam int c_phase_w  = $clog2(c_phase_max + 1);

  localparam logic [c_stable_w-1:0] c_stable_last  = c_stable_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_phase_w-1:0]  c_quiesce_last = c_phase_w'(QUIESCE_CYCLES - 1);
  localparam logic [c_phase_w-1:0]  c_settle_last  = c_phase_w'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOCK_WAIT = 3'd0,
    ST_RUN       = 3'd1,
    ST_QUIESCE   = 3'd2,
    ST_SWITCH    = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_ACK       = 3'd5
  } state_t;

  state_t                  r_state;
  logic                    r_lock_meta;
  logic                    r_lock_s;
  logic [c_stable_w-1:0]   r_stable_cnt;
  logic [c_phase_w-1:0]    r_phase_cnt;
  logic                    r_sel_latched;
  logic                    r_x2_sel;
  logic                    r_quiesce;
  logic                    r_sys_rst_n;
  logic                    r_rate_ack;
  logic                    r_lock_lost;
  logic [LOSS_CNT_W-1:0]   r_loss_cnt;
  logic                    w_lock_loss;

  // Every state other than LOCK_WAIT is entered with lock_s high and is left on
  // the first lock_s low cycle, so this is exactly the lock_s falling edge.
  assign w_lock_loss = (r_state != ST_LOCK_WAIT) && !r_lock_s;

  // Two-flop synchronizer for the asynchronous MMCM lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= mmcm_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer FSM with registered outputs; loss of lock overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_LOCK_WAIT;
      r_stable_cnt  <= '0;
      r_phase_cnt   <= '0;
      r_sel_latched <= 1'b0;
      r_x2_sel      <= 1'b0;
      r_quiesce     <= 1'b1;
      r_sys_rst_n   <= 1'b0;
      r_rate_ack    <= 1'b0;
      r_loss_cnt    <= '0;
    end else if (w_lock_loss) begin
      // Select is left as is: any switch already made stays made.
      r_state      <= ST_LOCK_WAIT;
      r_stable_cnt <= '0;
      r_phase_cnt  <= '0;
      r_quiesce    <= 1'b1;
      r_sys_rst_n  <= 1'b0;
      r_rate_ack   <= 1'b0;
      if (r_loss_cnt != '1) begin
        r_loss_cnt <= r_loss_cnt + 1'b1;
      end
    end else begin
      unique case (r_state)
        ST_LOCK_WAIT: begin
          if (!r_lock_s) begin
            r_stable_cnt <= '0;
          end else if (r_stable_cnt == c_stable_last) begin
            r_stable_cnt <= '0;
            r_state      <= ST_RUN;
            r_sys_rst_n  <= 1'b1;
            r_quiesce    <= 1'b0;
          end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (rate_if.rate_req) begin
            if (rate_if.rate_sel != r_x2_sel) begin
              r_sel_latched <= rate_if.rate_sel;
              r_quiesce     <= 1'b1;
              r_phase_cnt   <= '0;
              r_state       <= ST_QUIESCE;
            end else begin
              r_rate_ack <= 1'b1;
              r_state    <= ST_ACK;
            end
          end
        end
        ST_QUIESCE: begin
          if (r_phase_cnt == c_quiesce_last) begin
            r_phase_cnt <= '0;
            r_state     <= ST_SWITCH;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        ST_SWITCH: begin
          r_x2_sel    <= r_sel_latched;
          r_phase_cnt <= '0;
          r_state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_phase_cnt == c_settle_last) begin
            r_phase_cnt <= '0;
            r_quiesce   <= 1'b0;
            r_rate_ack  <= 1'b1;
            r_state     <= ST_ACK;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          if (!rate_if.rate_req) begin
            r_rate_ack <= 1'b0;
            r_state    <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_LOCK_WAIT;
        end
      endcase
    end
  end

  // Sticky loss flag; a new loss wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_lost <= 1'b0;
    end else if (w_lock_loss) begin
      r_lock_lost <= 1'b1;
    end else if (lock_lost_clr) begin
      r_lock_lost <= 1'b0;
    end
  end

  assign spi_clk_x2_sel   = r_x2_sel;
  assign spi_quiesce      = r_quiesce;
  assign sys_rst_n_out    = r_sys_rst_n;
  assign lock_lost        = r_lock_lost;
  assign lock_loss_cnt    = r_loss_cnt;
  assign seq_state        = r_state;
  assign rate_if.rate_ack = r_rate_ack;

endmodule

`default_nettype wire

// File: tb/tb_sys_clk_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_sys_clk_seq
// Purpose  : Self-checking bench for sys_clk_seq (scoreboard of timed snapshots).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sys_clk_seq;

  localparam int c_loss_w = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                mmcm_locked;
  logic                lock_lost_clr;
  logic                spi_clk_x2_sel;
  logic                spi_quiesce;
  logic                sys_rst_n_out;
  logic                lock_lost;
  logic [c_loss_w-1:0] lock_loss_cnt;
  logic [2:0]          seq_state;

  sys_clk_seq_if u_if ();

  sys_clk_seq #(
    .LOCK_STABLE_CYCLES (1024),
    .QUIESCE_CYCLES     (16),
    .SETTLE_CYCLES      (64),
    .LOSS_CNT_W         (c_loss_w)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mmcm_locked    (mmcm_locked),
    .rate_if        (u_if),
    .spi_clk_x2_sel (spi_clk_x2_sel),
    .spi_quiesce    (spi_quiesce),
    .sys_rst_n_out  (sys_rst_n_out),
    .lock_lost      (lock_lost),
    .lock_lost_clr  (lock_lost_clr),
    .lock_loss_cnt  (lock_loss_cnt),
    .seq_state      (seq_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fails = 0;

  // Scoreboard: expected output snapshot, tag and the cycle it is due at.
  string       tag_q[$];
  int          due_q[$];
  logic [9:0]  val_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Snapshot layout: {rst_n_out, quiesce, x2_sel, ack, lock_lost, loss_cnt[1:0], state[2:0]}
  function automatic logic [9:0] pk(input logic rst, input logic q, input logic sel,
                                    input logic ack, input logic lost,
                                    input logic [1:0] cnt, input logic [2:0] st);
    return {rst, q, sel, ack, lost, cnt, st};
  endfunction

  task automatic expect_at(input string tag, input int ofs, input logic [9:0] v);
    tag_q.push_back(tag);
    due_q.push_back(cyc + ofs);
    val_q.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare every snapshot that has fallen due, away from the active edge.
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      string      t;
      int         d;
      logic [9:0] v;
      t = tag_q.pop_front();
      d = due_q.pop_front();
      v = val_q.pop_front();
      check_val(t, {22'd0, sys_rst_n_out, spi_quiesce, spi_clk_x2_sel, u_if.rate_ack,
                    lock_lost, lock_loss_cnt, seq_state}, {22'd0, v});
    end
  end

  initial begin
    rst_n         = 1'b0;
    mmcm_locked   = 1'b0;
    lock_lost_clr = 1'b0;
    u_if.rate_req = 1'b0;
    u_if.rate_sel = 1'b0;
    step(3);
    expect_at("reset_state", 0, pk(0, 1, 0, 0, 0, 2'd0, 3'd0));
    step(1);
    rst_n = 1'b1;
    step(2);

    // Lock with a one-cycle dip during LOCK_WAIT; release counts from the re-rise.
    mmcm_locked = 1'b1;
    step(500);
    mmcm_locked = 1'b0;
    step(1);
    mmcm_locked = 1'b1;
    expect_at("release_hold", 1025, pk(0, 1, 0, 0, 0, 2'd0, 3'd0));
    expect_at("release",      1026, pk(1, 0, 0, 0, 0, 2'd0, 3'd1));
    step(1030);

    // Rate change 0 -> 1 with quiesce/switch/settle timing.
    u_if.rate_req = 1'b1;
    u_if.rate_sel = 1'b1;
    expect_at("chg_quiesce",    1,  pk(1, 1, 0, 0, 0, 2'd0, 3'd2));
    expect_at("chg_q_last",     16, pk(1, 1, 0, 0, 0, 2'd0, 3'd2));
    expect_at("chg_switch",     17, pk(1, 1, 0, 0, 0, 2'd0, 3'd3));
    expect_at("chg_sel",        18, pk(1, 1, 1, 0, 0, 2'd0, 3'd4));
    expect_at("chg_settle_end", 81, pk(1, 1, 1, 0, 0, 2'd0, 3'd4));
    expect_at("chg_ack",        82, pk(1, 0, 1, 1, 0, 2'd0, 3'd5));
    step(5);
    u_if.rate_sel = 1'b0;   // must be ignored once latched
    step(85);
    u_if.rate_req = 1'b0;
    expect_at("chg_ack_hold", 0, pk(1, 0, 1, 1, 0, 2'd0, 3'd5));
    expect_at("chg_ack_drop", 1, pk(1, 0, 1, 0, 0, 2'd0, 3'd1));
    step(3);

    // Same-rate request acknowledges without quiescing.
    u_if.rate_req = 1'b1;
    u_if.rate_sel = 1'b1;
    expect_at("same_ack", 1, pk(1, 0, 1, 1, 0, 2'd0, 3'd5));
    step(3);
    u_if.rate_req = 1'b0;
    expect_at("same_drop", 1, pk(1, 0, 1, 0, 0, 2'd0, 3'd1));
    step(3);

    // Lock loss during SETTLE of a 1 -> 0 change; the switched select is kept.
    u_if.rate_req = 1'b1;
    u_if.rate_sel = 1'b0;
    expect_at("loss_settle_sel", 18, pk(1, 1, 0, 0, 0, 2'd0, 3'd4));
    step(30);
    mmcm_locked = 1'b0;
    expect_at("loss1_pre",  2, pk(1, 1, 0, 0, 0, 2'd0, 3'd4));
    expect_at("loss1_hit",  3, pk(0, 1, 0, 0, 1, 2'd1, 3'd0));
    step(10);
    mmcm_locked = 1'b1;     // request still held across the re-lock
    expect_at("relock1",     1026, pk(1, 0, 0, 0, 1, 2'd1, 3'd1));
    expect_at("relock1_ack", 1027, pk(1, 0, 0, 1, 1, 2'd1, 3'd5));
    step(1030);
    u_if.rate_req = 1'b0;
    expect_at("relock1_drop", 1, pk(1, 0, 0, 0, 1, 2'd1, 3'd1));
    step(2);
    lock_lost_clr = 1'b1;
    step(1);
    lock_lost_clr = 1'b0;
    expect_at("lost_clr", 0, pk(1, 0, 0, 0, 0, 2'd1, 3'd1));
    step(2);

    // Loss in RUN with a clear in the same cycle: set wins.
    mmcm_locked = 1'b0;
    step(2);
    lock_lost_clr = 1'b1;
    expect_at("loss2_pre", 0, pk(1, 0, 0, 0, 0, 2'd1, 3'd1));
    expect_at("loss2_set", 1, pk(0, 1, 0, 0, 1, 2'd2, 3'd0));
    step(1);
    lock_lost_clr = 1'b0;

    // Further losses saturate the 2-bit counter at 3.
    for (int k = 3; k <= 5; k++) begin
      step(10);
      mmcm_locked = 1'b1;
      expect_at("relock_n", 1026, pk(1, 0, 0, 0, 1, 2'((k - 1 > 3) ? 3 : k - 1), 3'd1));
      step(1030);
      mmcm_locked = 1'b0;
      expect_at("loss_sat", 3, pk(0, 1, 0, 0, 1, 2'((k > 3) ? 3 : k), 3'd0));
      step(5);
    end

    // Asynchronous reset in the middle of QUIESCE.
    step(10);
    mmcm_locked = 1'b1;
    expect_at("relock_last", 1026, pk(1, 0, 0, 0, 1, 2'd3, 3'd1));
    step(1030);
    u_if.rate_req = 1'b1;
    u_if.rate_sel = 1'b1;
    expect_at("rst_quiesce_in", 1, pk(1, 1, 0, 0, 1, 2'd3, 3'd2));
    step(5);
    rst_n = 1'b0;
    expect_at("rst_async", 0, pk(0, 1, 0, 0, 0, 2'd0, 3'd0));
    expect_at("rst_hold",  1, pk(0, 1, 0, 0, 0, 2'd0, 3'd0));
    step(3);
    rst_n = 1'b1;
    u_if.rate_req = 1'b0;

    // Drain the scoreboard within a bounded window.
    for (int i = 0; i < 20 && due_q.size() > 0; i++) step(1);
    check_val("sb_drained", 32'(due_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sys_clk_seq.md
Name: sys_clk_seq

Overview:
- Sequencer on the opposite side of the system clock controller. It consumes the MMCM lock indication and drives the SPI x2 clock-mux select.
- Releases the system reset only after lock has been stable for a programmed time.
- Performs glitch-safe SPI clock-rate changes: request/ack handshake, quiesces SPI logic before switching, waits for settle after switching.
- Detects and counts loss-of-lock events.
- Clocked from the free-running reference clock, not an MMCM output, so it keeps running while the MMCM is unlocked.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before reset release (≥2).
- QUIESCE_CYCLES, 16: cycles spi_quiesce is held before the select changes (≥1).
- SETTLE_CYCLES, 64: cycles after the select change before quiesce drops (≥1).
- LOSS_CNT_W, 8: width of the loss-of-lock counter.

Ports:
- clk  in  1  free-running reference clock
- rst_n  in  1  asynchronous active-low reset
- mmcm_locked  in  1  MMCM lock, asynchronous to clk
- rate_req  in  1  level request for an SPI clock-rate change
- rate_sel  in  1  requested rate: 0 = 12.5 MHz, 1 = 50 MHz; valid while rate_req is high
- rate_ack  out  1  level acknowledge (4-phase handshake)
- spi_clk_x2_sel  out  1  clock-mux select to the clock controller
- spi_quiesce  out  1  high = SPI logic must hold idle
- sys_rst_n_out  out  1  system reset, active-low, synchronous to clk
- lock_lost  out  1  sticky loss-of-lock flag
- lock_lost_clr  in  1  single-cycle clear for lock_lost
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of loss-of-lock events
- seq_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset values (rst_n low, asynchronous): spi_clk_x2_sel=0, spi_quiesce=1, sys_rst_n_out=0, rate_ack=0, lock_lost=0, lock_loss_cnt=0, state=LOCK_WAIT, all counters 0.
- Lock synchronizer: mmcm_locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency). All lock logic uses lock_s only.
- State encodings: LOCK_WAIT=0, RUN=1, QUIESCE=2, SWITCH=3, SETTLE=4, ACK=5.
- LOCK_WAIT:
  - Stable counter increments each cycle lock_s=1; clears on any lock_s=0.
  - When count reaches LOCK_STABLE_CYCLES: go to RUN; sys_rst_n_out=1 and spi_quiesce=0 on the same edge.
  - Net: sys_rst_n_out rises LOCK_STABLE_CYCLES cycles after the first lock_s=1 cycle.
- RUN:
  - rate_req=1 and rate_sel≠spi_clk_x2_sel: latch rate_sel, assert spi_quiesce, go to QUIESCE.
  - rate_req=1 and rate_sel=spi_clk_x2_sel: go directly to ACK; no quiesce, select unchanged.
- QUIESCE: hold QUIESCE_CYCLES cycles, then go to SWITCH.
- SWITCH: one cycle; spi_clk_x2_sel takes the latched value on exit; go to SETTLE.
- SETTLE: hold SETTLE_CYCLES cycles; on exit deassert spi_quiesce and assert rate_ack; go to ACK.
- ACK: hold rate_ack=1 until rate_req=0, then rate_ack=0 on the next edge; go to RUN.
- Changes to rate_sel after latching are ignored until the next request.
- Loss of lock: lock_s falling (1→0) while in any state other than LOCK_WAIT, on the next edge:
  - sys_rst_n_out=0, spi_quiesce=1, rate_ack=0, lock_lost=1.
  - lock_loss_cnt increments, saturating at all-ones.
  - FSM goes to LOCK_WAIT and the stable counter clears.
  - spi_clk_x2_sel retains its current value; a select change already made in SETTLE is kept.
  - If rate_req is still high after re-lock, it is serviced again from RUN.
- A lock_s dip during LOCK_WAIT does not count as a loss event; it only clears the stable counter.
- lock_lost_clr clears lock_lost. If clear and a new loss occur in the same cycle, set wins.
- lock_loss_cnt clears only on rst_n.
- spi_clk_x2_sel never changes while spi_quiesce=0.

Test Plan:
- Reset release, LOCK_STABLE_CYCLES=1024: raise mmcm_locked → sys_rst_n_out and ~spi_quiesce rise exactly 1026±1 cycles after the raw edge; state=RUN.
- Lock glitch during LOCK_WAIT: lock high 500 cycles, low 1 cycle, high again → release occurs 1024 cycles after the second lock_s rise; lock_loss_cnt=0.
- Rate change 0→1 (QUIESCE=16, SETTLE=64):
  - req with sel=1 → spi_quiesce rises next edge.
  - spi_clk_x2_sel=1 after 17 cycles.
  - rate_ack=1 and spi_quiesce=0 after a further 64 cycles.
  - Drop req → ack low next edge, state=RUN.
- Same-rate request: sel=current → rate_ack high 1 cycle after req; spi_quiesce stays 0; select unchanged.
- Lock loss in SETTLE: drop mmcm_locked → 3 cycles later sys_rst_n_out=0, lock_lost=1, lock_loss_cnt=1, rate_ack=0, select kept. Re-lock with req held → full handshake repeats.
- Counter and flag edge cases:
  - LOSS_CNT_W=2, five loss events → lock_loss_cnt=3.
  - lock_lost_clr asserted in the same cycle as a loss → lock_lost stays 1.
  - rst_n asserted mid-QUIESCE → all outputs return to their reset values immediately.
